// File: rtl/uart_capture.sv
// rtl/uart_capture.sv - UART receive monitor with error-tagged FWFT receive FIFO
module uart_capture #(
    parameter int CLKS_PER_BIT = 280,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_rx,
    output logic [DATA_BITS-1:0]          o_data,
    output logic                          o_frame_err,
    output logic                          o_parity_err,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic                          o_overflow,
    input  logic                          i_clear,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_busy
);
    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int ENTRY_W = DATA_BITS + 2;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [TIMER_W-1:0] TIMER_HALF = TIMER_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
    localparam logic [3:0]         DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]         STOP_LAST  = 4'(STOP_BITS - 1);
    localparam logic [PTR_W:0]     FULL_CNT   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic               ODD_PAR    = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    logic                 sync1_q, sync2_q, rx_s;
    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d, timer_next;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 tick, push;
    logic [ENTRY_W-1:0]   entry, head;

    logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]       count_q, count_d;
    logic                 overflow_q, overflow_d;
    logic                 pop, full, do_push;

    assign rx_s       = sync2_q;
    assign tick       = (timer_q == TIMER_LAST);
    assign timer_next = tick ? '0 : timer_q + TIMER_W'(1);

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        push      = 1'b0;
        entry     = {shift_q, ferr_q | ~rx_s, perr_q};
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    timer_d = TIMER_HALF;
                end
            end
            S_START: begin
                timer_d = timer_next;
                if (tick) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                        ferr_d    = 1'b0;
                    end
                end
            end
            S_DATA: begin
                timer_d = timer_next;
                if (tick) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                timer_d = timer_next;
                if (tick) begin
                    perr_d  = (^shift_q) ^ rx_s ^ ODD_PAR;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                timer_d = timer_next;
                if (tick) begin
                    if (!rx_s) ferr_d = 1'b1;
                    if (bit_cnt_q == STOP_LAST) begin
                        push    = 1'b1;
                        state_d = rx_s ? S_IDLE : S_BREAK;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a frame when the head leaves in the same cycle.
    always_comb begin
        pop        = (count_q != '0) && i_ready;
        full       = (count_q == FULL_CNT);
        do_push    = push && (!full || pop);
        wr_ptr_d   = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d    = count_q;
        if (do_push && !pop) count_d = count_q + (PTR_W + 1)'(1);
        if (!do_push && pop) count_d = count_q - (PTR_W + 1)'(1);
        overflow_d = overflow_q;
        if (i_clear) overflow_d = 1'b0;
        if (push && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            state_q    <= S_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= i_rx;
            sync2_q    <= sync1_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) fifo_mem_q[wr_ptr_q] <= entry;
    end

    // Head fields are forced to zero while empty so reset presents all-zero outputs.
    assign head         = fifo_mem_q[rd_ptr_q];
    assign o_valid      = (count_q != '0);
    assign o_data       = o_valid ? head[ENTRY_W-1:2] : '0;
    assign o_frame_err  = o_valid & head[1];
    assign o_parity_err = o_valid & head[0];
    assign o_count      = count_q;
    assign o_overflow   = overflow_q;
    assign o_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_capture.sv
// tb/tb_uart_capture.sv - randomized self-checking bench for uart_capture with a queue model
module tb_uart_capture;
    localparam int C0 = 280;
    localparam int C1 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst_n, rx, ready, clear;
    logic [7:0] d0;
    logic [6:0] d1;
    logic       fe0, pe0, v0, ov0, b0, fe1, pe1, v1, ov1, b1;
    logic [4:0] cnt0;
    logic [2:0] cnt1;

    logic [8:0] data_w  [2];
    logic [4:0] count_w [2];
    logic [1:0] valid_w, fe_w, pe_w, ov_w, busy_w;

    uart_capture u0 (
        .i_clk(clk), .i_rst_n(rst_n[0]), .i_rx(rx[0]), .o_data(d0),
        .o_frame_err(fe0), .o_parity_err(pe0), .o_valid(v0), .i_ready(ready[0]),
        .o_overflow(ov0), .i_clear(clear[0]), .o_count(cnt0), .o_busy(b0)
    );

    uart_capture #(
        .CLKS_PER_BIT(C1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)
    ) u1 (
        .i_clk(clk), .i_rst_n(rst_n[1]), .i_rx(rx[1]), .o_data(d1),
        .o_frame_err(fe1), .o_parity_err(pe1), .o_valid(v1), .i_ready(ready[1]),
        .o_overflow(ov1), .i_clear(clear[1]), .o_count(cnt1), .o_busy(b1)
    );

    assign data_w[0]  = {1'b0, d0};
    assign data_w[1]  = {2'b00, d1};
    assign count_w[0] = cnt0;
    assign count_w[1] = {2'b00, cnt1};
    assign valid_w    = {v1, v0};
    assign fe_w       = {fe1, fe0};
    assign pe_w       = {pe1, pe0};
    assign ov_w       = {ov1, ov0};
    assign busy_w     = {b1, b0};

    function automatic int cpb(input int i);    return (i == 0) ? C0 : C1; endfunction
    function automatic int nbits(input int i);  return (i == 0) ? 8 : 7;   endfunction
    function automatic int par(input int i);    return (i == 0) ? 0 : 2;   endfunction
    function automatic int nstop(input int i);  return (i == 0) ? 1 : 2;   endfunction
    function automatic int depth(input int i);  return (i == 0) ? 16 : 4;  endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model: expected entries {data, frame_err, parity_err} per instance.
    logic [10:0] q0[$];
    logic [10:0] q1[$];
    logic [1:0]  mov = 2'b00;
    logic        rand_en = 1'b0;
    int          lat_n;

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    task automatic model_push(input int i, input logic [10:0] e);
        if (qsize(i) == depth(i) && !ready[i]) mov[i] = 1'b1;
        else if (i == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int i, input logic [8:0] data, input bit bad_par,
                              input int stop_low, input bit expect_push);
        logic [8:0] mask, d;
        logic       pbit;
        int         nb, c, k;
        nb   = nbits(i);
        c    = cpb(i);
        mask = 9'((1 << nb) - 1);
        d    = data & mask;
        pbit = (^d) ^ (par(i) == 1) ^ bad_par;
        k    = 2 + c / 2 + (nb + (par(i) != 0 ? 1 : 0) + nstop(i)) * c;
        fork
            begin
                rx[i] = 1'b0;
                tick(c);
                for (int b = 0; b < nb; b++) begin
                    rx[i] = d[b];
                    tick(c);
                end
                if (par(i) != 0) begin
                    rx[i] = pbit;
                    tick(c);
                end
                if (stop_low > 0) begin
                    rx[i] = 1'b0;
                    tick(stop_low * c);
                end
                rx[i] = 1'b1;
                tick(nstop(i) * c);
            end
            begin
                tick(k);
                #1;
                if (expect_push) model_push(i, {d, stop_low > 0, bad_par && par(i) != 0});
            end
        join
    endtask

    always @(negedge clk) begin
        logic [10:0] e;
        for (int i = 0; i < 2; i++) begin
            if (rst_n[i] && valid_w[i] && ready[i]) begin
                if (qsize(i) == 0) begin
                    check((i == 0) ? "u0_spurious_pop" : "u1_spurious_pop", 32'(1), 32'(0));
                end else begin
                    e = (i == 0) ? q0.pop_front() : q1.pop_front();
                    check((i == 0) ? "u0_data" : "u1_data", 32'(data_w[i]), 32'(e[10:2]));
                    check((i == 0) ? "u0_frame_err" : "u1_frame_err", 32'(fe_w[i]), 32'(e[1]));
                    check((i == 0) ? "u0_parity_err" : "u1_parity_err", 32'(pe_w[i]), 32'(e[0]));
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            ready[1] = ($urandom_range(0, 255) == 0);
        end
    end

    initial begin
        rst_n = 2'b00;
        rx    = 2'b11;
        ready = 2'b00;
        clear = 2'b00;
        tick(3);
        for (int i = 0; i < 2; i++) begin
            check("rst_valid", 32'(valid_w[i]), 32'(0));
            check("rst_count", 32'(count_w[i]), 32'(0));
            check("rst_overflow", 32'(ov_w[i]), 32'(0));
            check("rst_busy", 32'(busy_w[i]), 32'(0));
            check("rst_data", 32'({data_w[i], fe_w[i], pe_w[i]}), 32'(0));
        end
        rst_n = 2'b11;
        tick(3);

        // Default format: first-frame latency and two clean bytes.
        ready[0] = 1'b1;
        fork
            send_frame(0, 9'h48, 1'b0, 0, 1'b1);
            begin
                lat_n = -1;
                do begin
                    @(negedge clk);
                    lat_n++;
                end while (!valid_w[0] && lat_n < 4000);
                check("u0_latency", 32'(lat_n), 32'(3 + 140 + 9 * 280));
            end
        join
        send_frame(0, 9'h69, 1'b0, 0, 1'b1);
        tick(20);
        check("u0_drained", 32'(q0.size()), 32'(0));

        // Start glitch shorter than half a bit.
        rx[0] = 1'b0;
        tick(C0 / 4);
        check("glitch_busy", 32'(busy_w[0]), 32'(1));
        rx[0] = 1'b1;
        tick(200);
        check("glitch_busy_end", 32'(busy_w[0]), 32'(0));
        check("glitch_count", 32'(count_w[0]), 32'(0));

        // Stop bit held low for three bit-times, then a clean frame.
        send_frame(0, 9'h0A5, 1'b0, 3, 1'b1);
        tick(2 * C0);
        send_frame(0, 9'h001, 1'b0, 0, 1'b1);
        tick(20);
        check("break_drained", 32'(q0.size()), 32'(0));
        check("break_count", 32'(count_w[0]), 32'(0));
        check("break_busy", 32'(busy_w[0]), 32'(0));

        // Even parity, 7 data bits: good then corrupted parity.
        ready[1] = 1'b1;
        send_frame(1, 9'h55, 1'b0, 0, 1'b1);
        send_frame(1, 9'h55, 1'b1, 0, 1'b1);
        tick(20);
        check("parity_drained", 32'(q1.size()), 32'(0));

        // Fill a depth-4 FIFO with six frames and no consumer.
        ready[1] = 1'b0;
        for (int v = 16; v < 22; v++) send_frame(1, 9'(v), 1'b0, 0, 1'b1);
        tick(10);
        check("ovf_count", 32'(count_w[1]), 32'(4));
        check("ovf_flag", 32'(ov_w[1]), 32'(mov[1]));
        check("ovf_flag_set", 32'(ov_w[1]), 32'(1));
        check("ovf_head", 32'(data_w[1]), 32'(9'h10));
        clear[1] = 1'b1;
        mov[1]   = 1'b0;
        tick(1);
        clear[1] = 1'b0;
        check("ovf_cleared", 32'(ov_w[1]), 32'(0));

        // Push on the exact cycle a pop frees the full FIFO.
        fork
            send_frame(1, 9'h16, 1'b0, 0, 1'b1);
            begin
                tick(2 + C1 / 2 + 10 * C1);
                ready[1] = 1'b1;
                tick(1);
                ready[1] = 1'b0;
            end
        join
        tick(5);
        check("coinc_count", 32'(count_w[1]), 32'(4));
        check("coinc_overflow", 32'(ov_w[1]), 32'(0));
        ready[1] = 1'b1;
        tick(10);
        check("coinc_drained", 32'(q1.size()), 32'(0));
        check("coinc_count_end", 32'(count_w[1]), 32'(0));

        // Reset in the middle of the data bits of 0x3C.
        rx[1] = 1'b0;
        tick(C1);
        rx[1] = 1'b0; tick(C1);
        rx[1] = 1'b0; tick(C1);
        rx[1] = 1'b1; tick(C1 / 2);
        check("mid_busy", 32'(busy_w[1]), 32'(1));
        rst_n[1] = 1'b0;
        #1;
        check("async_rst_busy", 32'(busy_w[1]), 32'(0));
        check("async_rst_out", 32'({data_w[1], fe_w[1], pe_w[1], valid_w[1], ov_w[1]}), 32'(0));
        tick(5);
        rst_n[1] = 1'b1;
        tick(30);
        check("post_rst_busy", 32'(busy_w[1]), 32'(0));
        check("post_rst_count", 32'(count_w[1]), 32'(0));
        send_frame(1, 9'h7E, 1'b0, 0, 1'b1);
        tick(20);
        check("rst_drained", 32'(q1.size()), 32'(0));

        // Random frames with a slow random consumer.
        rand_en = 1'b1;
        for (int n = 0; n < 24; n++) begin
            logic [8:0] dat;
            bit         bad;
            int         sl;
            dat = 9'($urandom);
            bad = ($urandom_range(0, 3) == 0);
            sl  = ($urandom_range(0, 4) == 0) ? 2 + $urandom_range(0, 1) : 0;
            send_frame(1, dat, bad, sl, 1'b1);
            tick(1 + $urandom_range(0, 20));
        end
        rand_en = 1'b0;
        tick(2);
        check("rand_overflow", 32'(ov_w[1]), 32'(mov[1]));
        check("rand_count", 32'(count_w[1]), 32'(q1.size()));
        ready[1] = 1'b1;
        tick(40);
        check("rand_drained", 32'(q1.size()), 32'(0));
        check("rand_count_end", 32'(count_w[1]), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_capture.md
# uart_capture

Synthesizable, parametrised UART receive monitor that attaches to the SoC serial output `q` in simulation and on hardware. It captures the UART stream of the `servive` SoC into a buffer with per-byte error status. It replaces the fixed-rate, print-only decoder with configurable frame format, a receive FIFO, and error and overflow reporting. It sits beside the SoC on the same clock domain and is read over a valid/ready port.

## Interface
Parameters:
- `CLKS_PER_BIT`, 280: clock cycles per UART bit (16.13 MHz / 57600); must be ≥ 8.
- `DATA_BITS`, 8: data bits per frame; range 5–9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: receive FIFO entries; power of two, ≥ 2.

Ports:
- `i_clk` in 1: system clock.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_rx` in 1: serial line, idle high; asynchronous to the data framing.
- `o_data` out DATA_BITS: head-of-FIFO data byte.
- `o_frame_err` out 1: head entry had a low stop bit.
- `o_parity_err` out 1: head entry failed parity; always 0 when PARITY = 0.
- `o_valid` out 1: FIFO non-empty.
- `i_ready` in 1: consumer pops the head when `o_valid & i_ready`.
- `o_overflow` out 1: sticky; a frame was dropped because the FIFO was full.
- `i_clear` in 1: synchronous clear of `o_overflow`.
- `o_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `o_busy` out 1: receiver FSM is not in IDLE.

## Operation
- `i_rx` passes through a 2-FF synchronizer that resets to 1. All logic uses the synchronized line `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- The bit timer counts 0..CLKS_PER_BIT-1. Its "sample" tick occurs when it reaches its terminal value.
- **IDLE:** when `rx_s` = 0, go to START. The timer is loaded so the first sample falls CLKS_PER_BIT/2 cycles later (mid-bit).
- **START:** at the sample, if `rx_s` = 1 (glitch), return to IDLE with no push and no error. Otherwise go to DATA and reload the timer to a full bit.
- **DATA:** take DATA_BITS samples, LSB first, shifting into the data register. Then go to PARITY if PARITY ≠ 0, else STOP.
- **PARITY:** take one sample. `parity_err` = (XOR of data and parity bit) ≠ (PARITY == 1 ? 1 : 0).
- **STOP:** take STOP_BITS samples. `frame_err` is set if any stop sample is 0.
  - On the final stop sample, push {data, frame_err, parity_err} into the FIFO.
  - Then go to BREAK if the last stop sample was 0, else IDLE.
- **BREAK:** stay until `rx_s` = 1, then go to IDLE. No new frame is detected while the line is held low.
- **FIFO:** first-word-fall-through. `o_data` and both error flags reflect the head entry whenever `o_valid` = 1; they are don't-care otherwise.
- **Push when full:**
  - With no pop that cycle: drop the new frame, set `o_overflow`; FIFO contents are unchanged.
  - With a pop the same cycle: accept the push; count is unchanged.
- **Push and pop on a non-full, non-empty FIFO:** count is unchanged.
- **Pop on empty:** ignored.
- Pointers wrap modulo FIFO_DEPTH. Occupancy is held in a separate counter.
- **`o_overflow`:** set has priority over `i_clear` in the same cycle.

## Timing
- Reset values:
  - FSM in IDLE, synchronizer = 1, pointers and count = 0.
  - `o_valid`=0, `o_count`=0, `o_overflow`=0, `o_busy`=0.
  - `o_data` and error flags are 0.
- Reset is asynchronous. Reset mid-frame abandons the frame: no push, no error. After release, the block waits for a fresh falling edge.
- Cycle T0 is the first cycle with `rx_s` = 0.
  - Start sample at T0 + CLKS_PER_BIT/2.
  - Sample k (k ≥ 1) at T0 + CLKS_PER_BIT/2 + k·CLKS_PER_BIT.
- The push occurs on the final stop-sample cycle. `o_valid` and the new `o_count` are visible the following cycle.
- Total from `i_rx` falling to `o_valid`: 3 + CLKS_PER_BIT/2 + (DATA_BITS + P + STOP_BITS)·CLKS_PER_BIT cycles, where P = (PARITY ≠ 0).
- Pop takes effect at the clock edge where `o_valid & i_ready` = 1. The next head is presented the following cycle.
- `o_busy` is high from T0+1 until the cycle after the FSM returns to IDLE.

## Test plan
- **Default parameters:** send 0x48, 0x69 with `i_ready`=1.
  - Two pops, data 0x48 then 0x69, no error flags.
  - `o_valid` first rises exactly 3+140+9·280 cycles after the falling edge.
- **PARITY=2, DATA_BITS=7:** send 0x55 with correct parity, then 0x55 with the parity bit flipped.
  - First entry `o_parity_err`=0, second =1, data 0x55 in both.
- **Stop bit held low for 3 bit-times after 0xA5:**
  - Entry 0xA5 with `o_frame_err`=1.
  - No spurious second frame; the next frame 0x01 is received clean.
- **Glitch:** `i_rx` low for CLKS_PER_BIT/4 cycles → no push, `o_busy` returns to 0, `o_count` stays 0.
- **FIFO_DEPTH=4, `i_ready`=0:** send 6 bytes 0x10–0x15.
  - `o_count`=4, `o_overflow`=1, FIFO holds 0x10–0x13.
  - `i_clear` clears `o_overflow`.
  - A push coinciding with a pop while full is accepted.
- **Reset:** assert `i_rst_n`=0 mid-DATA of 0x3C, release, then send 0x7E → only 0x7E is captured, all outputs 0 during reset.
